// File: rtl/button_bank.sv
// button_bank: input conditioner for N push-buttons.
//
// Each channel runs a SYNC_STAGES-deep synchroniser, a counter debouncer,
// press/release edge detection and an optional auto-repeat generator.
// All outputs are registered.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   ena        global enable; low freezes all state and forces pulses to 0
//   btn_in     [N] raw asynchronous buttons, active-high
//   repeat_en  [N] per-channel auto-repeat enable
//   level      [N] debounced button state
//   press      [N] one-cycle pulse on debounced rise and on each repeat tick
//   released   [N] one-cycle pulse on debounced fall ("release" itself is a
//                  reserved word in SystemVerilog, so the port carries this name)
module button_bank #(
  parameter int N               = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  input  logic [N-1:0] btn_in,
  input  logic [N-1:0] repeat_en,
  output logic [N-1:0] level,
  output logic [N-1:0] press,
  output logic [N-1:0] released
);

  localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX);

  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RC_DELAY  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RC_PERIOD = RW'(REPEAT_PERIOD - 1);

  logic [SYNC_STAGES-1:0] sync_p0 [N];
  logic [CW-1:0]          cnt     [N];
  logic [RW-1:0]          rc      [N];

  logic [N-1:0]  s;
  logic [N-1:0]  lvl_nxt;
  logic [N-1:0]  rise;
  logic [N-1:0]  fall;
  logic [N-1:0]  tick;
  logic [CW-1:0] cnt_nxt [N];
  logic [RW-1:0] rc_nxt  [N];

  // Stage boundary: synchroniser output -> debounce / edge / repeat decisions
  always_comb begin
    for (int i = 0; i < N; i++) begin
      s[i]       = sync_p0[i][SYNC_STAGES-1];
      lvl_nxt[i] = level[i];
      cnt_nxt[i] = '0;
      if (s[i] != level[i]) begin
        if (cnt[i] == CNT_LAST) lvl_nxt[i] = s[i];
        else                    cnt_nxt[i] = cnt[i] + 1'b1;
      end
      rise[i] = lvl_nxt[i] & ~level[i];
      fall[i] = ~lvl_nxt[i] & level[i];
      // Requiring the level to stay high through this edge keeps a repeat
      // tick from landing on the same cycle as a release pulse.
      tick[i] = level[i] & lvl_nxt[i] & repeat_en[i] & (rc[i] == '0);
      // A rising edge always comes from level==0, so the hold branch also
      // covers the reload on a fresh press.
      if (!level[i] || !repeat_en[i]) rc_nxt[i] = RC_DELAY;
      else if (rc[i] == '0)           rc_nxt[i] = RC_PERIOD;
      else                            rc_nxt[i] = rc[i] - 1'b1;
    end
  end

  // Stage boundary: registered state and outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        sync_p0[i] <= '0;
        cnt[i]     <= '0;
        rc[i]      <= RC_DELAY;
      end
      level    <= '0;
      press    <= '0;
      released <= '0;
    end else if (ena) begin
      for (int i = 0; i < N; i++) begin
        sync_p0[i] <= {sync_p0[i][SYNC_STAGES-2:0], btn_in[i]};
        cnt[i]     <= cnt_nxt[i];
        rc[i]      <= rc_nxt[i];
      end
      level    <= lvl_nxt;
      press    <= rise | tick;
      released <= fall;
    end else begin
      press    <= '0;
      released <= '0;
    end
  end

endmodule

// File: tb/tb_button_bank.sv
// tb_button_bank: scoreboard bench for button_bank.
// The driver applies each cycle's inputs, advances a time-based reference
// model and queues the expected outputs; a monitor pops one entry per rising
// edge and compares it against the DUT.
module tb_button_bank;

  localparam int N   = 4;
  localparam int SS  = 2;
  localparam int DEB = 16;
  localparam int RD  = 64;
  localparam int RP  = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ena;
  logic [N-1:0] btn_in;
  logic [N-1:0] repeat_en;
  logic [N-1:0] level;
  logic [N-1:0] press;
  logic [N-1:0] released;

  always #5 clk = ~clk;

  button_bank #(
    .N(N), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .btn_in(btn_in),
    .repeat_en(repeat_en), .level(level), .press(press), .released(released)
  );

  typedef struct packed {
    logic [N-1:0] lvl;
    logic [N-1:0] prs;
    logic [N-1:0] rel;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   pcnt[N];
  int   rcnt[N];

  // Reference model: delayed sample stream, length of the current
  // disagreement run, and elapsed time since the press (or since repeat
  // became enabled while held).
  bit pipe[N][$];
  int run[N];
  int age[N];
  bit mlvl[N];

  function automatic exp_t model_step(logic r_n, logic en, logic [N-1:0] b, logic [N-1:0] re);
    exp_t e;
    e = '0;
    for (int i = 0; i < N; i++) begin
      bit s;
      bit lold;
      bit rise;
      bit tk;
      if (!r_n) begin
        pipe[i].delete();
        for (int k = 0; k < SS; k++) pipe[i].push_back(1'b0);
        run[i]  = 0;
        age[i]  = 0;
        mlvl[i] = 1'b0;
      end else if (en) begin
        s = pipe[i].pop_front();
        pipe[i].push_back(b[i]);
        lold = mlvl[i];
        if (s != mlvl[i]) begin
          run[i]++;
          if (run[i] == DEB) begin
            mlvl[i] = s;
            run[i]  = 0;
          end
        end else begin
          run[i] = 0;
        end
        rise = !lold && mlvl[i];
        if (!lold || !re[i]) age[i] = 0;
        else                 age[i]++;
        tk = lold && mlvl[i] && re[i] && age[i] >= RD && ((age[i] - RD) % RP) == 0;
        e.prs[i] = rise || tk;
        e.rel[i] = lold && !mlvl[i];
      end
      e.lvl[i] = mlvl[i];
    end
    return e;
  endfunction

  function automatic void chk(string nm, logic [N-1:0] act, logic [N-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, req);
    end
  endfunction

  function automatic void cnt_chk(string nm, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endfunction

  function automatic void clr();
    for (int i = 0; i < N; i++) begin
      pcnt[i] = 0;
      rcnt[i] = 0;
    end
  endfunction

  // Called at a falling edge (or time 0) with inputs already set.
  task automatic drive(int n);
    for (int k = 0; k < n; k++) begin
      sb.push_back(model_step(rst_n, ena, btn_in, repeat_en));
      @(negedge clk);
    end
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("level", level, e.lvl);
        chk("press", press, e.prs);
        chk("release", released, e.rel);
        chk("press_and_release", press & released, '0);
        for (int i = 0; i < N; i++) begin
          if (press[i])    pcnt[i]++;
          if (released[i]) rcnt[i]++;
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int tot;
    clr();
    // Reset with buttons high
    rst_n = 1'b0; ena = 1'b1; btn_in = '1; repeat_en = '0;
    drive(3);
    rst_n = 1'b1; btn_in = '0;
    clr();
    drive(50);
    tot = 0;
    for (int i = 0; i < N; i++) tot += pcnt[i] + rcnt[i];
    cnt_chk("idle_pulses", tot, 0);

    // Clean press / hold / release on ch0
    clr();
    btn_in = 4'b0001;
    drive(218);
    btn_in = '0;
    drive(30);
    cnt_chk("ch0_press_count", pcnt[0], 1);
    cnt_chk("ch0_release_count", rcnt[0], 1);

    // Bounce on ch1, then a 15-cycle glitch and a 16-cycle pulse
    clr();
    for (int k = 0; k < 20; k++) begin
      btn_in[1] = (k % 2 == 0);
      drive(5);
    end
    btn_in = '0; drive(20);
    btn_in[1] = 1'b1; drive(15);
    btn_in[1] = 1'b0; drive(20);
    cnt_chk("ch1_bounce_press", pcnt[1], 0);
    btn_in[1] = 1'b1; drive(16);
    btn_in[1] = 1'b0; drive(40);
    cnt_chk("ch1_pulse_press", pcnt[1], 1);
    cnt_chk("ch1_pulse_release", rcnt[1], 1);

    // Auto-repeat on ch2: level high for 120 cycles
    clr();
    repeat_en = 4'b0100; btn_in = 4'b0100;
    drive(120);
    btn_in = '0;
    drive(40);
    cnt_chk("ch2_repeat_press", pcnt[2], 5);
    cnt_chk("ch2_repeat_release", rcnt[2], 1);

    // Auto-repeat disabled at T+70
    clr();
    btn_in = 4'b0100;
    drive(87);
    repeat_en = '0;
    drive(33);
    btn_in = '0;
    drive(40);
    cnt_chk("ch2_repeat_cut_press", pcnt[2], 2);

    // All channels together
    clr();
    btn_in = '1;
    drive(30);
    btn_in = '0;
    drive(30);
    for (int i = 0; i < N; i++) cnt_chk("all_press", pcnt[i], 1);

    // Enable dropped during the debounce window
    clr();
    btn_in = '1;
    drive(5);
    ena = 1'b0; drive(10);
    ena = 1'b1; drive(30);
    btn_in = '0; drive(30);
    cnt_chk("ena_press_ch3", pcnt[3], 1);

    // Reset while ch2 repeats
    clr();
    repeat_en = 4'b0100; btn_in = 4'b0100;
    drive(100);
    rst_n = 1'b0; drive(1);
    rst_n = 1'b1; drive(100);
    cnt_chk("reset_no_release", rcnt[2], 0);
    btn_in = '0; drive(40);

    // Random phases: fast toggling, then slow toggling for repeat coverage
    for (int ph = 0; ph < 2; ph++) begin
      for (int k = 0; k < 2500; k++) begin
        for (int i = 0; i < N; i++)
          if ($urandom_range(0, (ph == 0) ? 24 : 149) == 0) btn_in[i] = ~btn_in[i];
        ena   = ($urandom_range(0, 19) != 0);
        rst_n = ($urandom_range(0, 799) != 0);
        if ($urandom_range(0, 199) == 0) repeat_en = N'($urandom);
        drive(1);
      end
    end
    rst_n = 1'b1; ena = 1'b1;
    drive(2);

    cnt_chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
